des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Parametrised DES/3DES subkey scheduler that replaces the fixed single-key generator. It holds up to three software-loadable 64-bit keys. On `start` it streams the 48-bit round subkeys for one full single-DES or EDE-3DES operation, in encrypt or decrypt order, over a valid/ready handshake. It sits between the key-load path and the Feistel round datapath.

## Interface
- `NUM_KEYS`, default 3: number of key slots; legal values 1 (single DES) or 3 (EDE 3DES).
- `SHIFT_SCHED`, default 16'b1000_0001_0000_0011: bit r-1 = 1 means a rotate of 1 for round r, 0 means a rotate of 2.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_wr_en` in 1: key slot write strobe.
- `key_wr_idx` in 2: slot index.
- `key_wr_data` in 64: key value, DES bit 1 = [63].
- `start` in 1: begin a schedule run.
- `decrypt` in 1: direction, sampled with `start`.
- `busy` out 1: run in progress.
- `subkey` out 48: current subkey, PC-2 bit 1 = [47].
- `subkey_valid` out 1: subkey presented.
- `subkey_ready` in 1: consumer accepts.
- `subkey_round` out 4: round index 0..15 (round r-1).
- `subkey_pass` out 2: pass index 0..NUM_KEYS-1.
- `done` out 1: one-cycle pulse at end of run.

## Operation
- Reset clears all key slots to 0, state to IDLE, and C/D registers to 0. All outputs read 0.
- Key writes take effect only in IDLE. Writes with `key_wr_idx` ≥ NUM_KEYS are ignored. Writes while `busy` are ignored.
- `start` is accepted only in IDLE. It latches `decrypt`. `start` while busy is ignored.
- Pass order for encrypt: slots 0,1,2 with directions E,D,E. For decrypt: slots 2,1,0 with directions D,E,D. When NUM_KEYS=1 there is a single pass: slot 0 in direction E (encrypt) or D (decrypt).
- The FSM has four states: IDLE → LOAD → EMIT → (LOAD for the next pass | DONE) → IDLE.
- LOAD, one cycle:
  - C‖D = PC-1(key) per FIPS 46-3.
  - In E direction, the first rotate-left by s1 is also applied.
  - Round is set to 0.
- EMIT:
  - `subkey_valid`=1 and `subkey` = PC-2(C‖D).
  - On `subkey_valid`&&`subkey_ready`, round increments.
  - The next C‖D in E direction is rotl(C,s_{r+1}) and rotl(D,s_{r+1}).
  - The next C‖D in D direction is rotr(C,s_{17-r}) and rotr(D,s_{17-r}), where r is the 1-based round just emitted. Round 1 in D direction uses unrotated PC-1, i.e. C16=C0.
  - C and D rotate independently within 28 bits, with wrap-around.
- After the handshake on round 15 (0-based), the FSM goes to LOAD for the next pass if one remains, otherwise to DONE.
- DONE lasts one cycle: `done`=1, `busy`=0 next cycle, state returns to IDLE.
- `subkey` is gated to 0 whenever `subkey_valid`=0.

## Timing
- `start` sampled at edge T: `busy`=1 from T+1, LOAD in T+1, first `subkey_valid` at T+2.
- With `subkey_ready` held high: one subkey per cycle, then a one-cycle bubble (LOAD) between passes.
- Total length is 17·NUM_KEYS cycles from T+1 to the last handshake. `done` is high the cycle after the last handshake.
- While `subkey_valid`&&!`subkey_ready`, `subkey`, `subkey_round` and `subkey_pass` are held stable. The handshake must not be dropped or duplicated.
- `busy` stays high from LOAD through the DONE cycle inclusive.
- Reset asserted mid-run has immediate effect (asynchronous): valid, busy and done go to 0, state goes to IDLE, and keys are cleared.

## Test plan
- **Single-DES encrypt.** NUM_KEYS=1, slot0=133457799BBCDFF1, start with decrypt=0, ready=1. Expect:
  - first valid at T+2 with subkey 1B02EFFC7072, round 0;
  - round 15 subkey CB3D8B0E17F5;
  - done pulse exactly one cycle later.
- **Single-DES decrypt.** Same key, decrypt=1. Expect round 0 = CB3D8B0E17F5 and round 15 = 1B02EFFC7072.
- **EDE-3DES encrypt.** NUM_KEYS=3, all slots 133457799BBCDFF1, encrypt. Expect:
  - pass 0 round 0 = 1B02EFFC7072;
  - pass 1 round 0 = CB3D8B0E17F5;
  - pass 2 round 0 = 1B02EFFC7072;
  - 48 handshakes with one-cycle valid-low bubbles between passes; done after 51 cycles.
- **Backpressure.** ready=0 for 5 cycles while presenting pass 0 round 6. Expect subkey, round and pass constant, then round 7 follows. The full sequence matches the single-DES encrypt case.
- **Reset mid-run.** Assert rst during pass 0 round 8. Expect valid, busy and done = 0 in the same cycle. Then start with no writes: 16 subkeys of 000000000000.
- **Ignored writes and starts.**
  - A key write while busy does not alter the current or next run.
  - key_wr_idx=3 is ignored.
  - A second start while busy does not restart the run; the round sequence continues unbroken.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES / EDE-3DES round-subkey streamer: LOAD takes one cycle per pass, then one subkey per accepted handshake.
// Backpressure: while subkey_valid && !subkey_ready the subkey, round and pass hold and C/D do not advance.
module des_key_schedule #(
  parameter int          NUM_KEYS    = 3,
  parameter logic [15:0] SHIFT_SCHED = 16'b1000_0001_0000_0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_wr_en,
  input  logic [1:0]  key_wr_idx,
  input  logic [63:0] key_wr_data,
  input  logic        start,
  input  logic        decrypt,
  output logic        busy,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  subkey_round,
  output logic [1:0]  subkey_pass,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Tables use FIPS bit numbering: bit 1 is the MSB of the vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  logic [1:0]  state;
  logic [63:0] key_slot [3];
  logic        dec_run;
  logic [1:0]  pass;
  logic [3:0]  round;
  logic [27:0] c_reg, d_reg;

  logic [1:0]  slot_idx;
  logic        pass_dec;
  logic [55:0] pc1_out;
  logic [27:0] c_load, d_load, c_next, d_next;
  logic [3:0]  sh_idx;
  logic        shift_one;
  logic        last_pass;

  // Decrypt runs the slots in reverse; the middle 3DES pass flips direction.
  always_comb begin
    slot_idx  = dec_run ? (2'(NUM_KEYS - 1) - pass) : pass;
    pass_dec  = (NUM_KEYS == 1) ? dec_run : (dec_run ^ (pass == 2'd1));
    last_pass = (pass == 2'(NUM_KEYS - 1));
    pc1_out   = pc1_perm(key_slot[slot_idx]);
    c_load    = pass_dec ? pc1_out[55:28] : rotl28(pc1_out[55:28], SHIFT_SCHED[0]);
    d_load    = pass_dec ? pc1_out[27:0]  : rotl28(pc1_out[27:0],  SHIFT_SCHED[0]);
    // Encrypt pre-rotates for the next round; decrypt undoes the rotation of the round just emitted.
    sh_idx    = pass_dec ? (4'd15 - round) : (round + 4'd1);
    shift_one = SHIFT_SCHED[sh_idx];
    c_next    = pass_dec ? rotr28(c_reg, shift_one) : rotl28(c_reg, shift_one);
    d_next    = pass_dec ? rotr28(d_reg, shift_one) : rotl28(d_reg, shift_one);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      dec_run <= 1'b0;
      pass    <= 2'd0;
      round   <= 4'd0;
      c_reg   <= '0;
      d_reg   <= '0;
      for (int i = 0; i < 3; i++) key_slot[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_wr_en && (key_wr_idx < 2'(NUM_KEYS))) key_slot[key_wr_idx] <= key_wr_data;
          if (start) begin
            dec_run <= decrypt;
            pass    <= 2'd0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          c_reg <= c_load;
          d_reg <= d_load;
          round <= 4'd0;
          state <= S_EMIT;
        end
        S_EMIT: begin
          if (subkey_ready) begin
            c_reg <= c_next;
            d_reg <= d_next;
            round <= round + 4'd1;
            if (round == 4'd15) begin
              if (last_pass) begin
                state <= S_DONE;
              end else begin
                pass  <= pass + 2'd1;
                state <= S_LOAD;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state != S_IDLE);
    subkey_valid = (state == S_EMIT);
    done         = (state == S_DONE);
    subkey       = subkey_valid ? pc2_perm({c_reg, d_reg}) : 48'h0;
    subkey_round = round;
    subkey_pass  = pass;
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: a NUM_KEYS=1 and a NUM_KEYS=3 instance share all inputs.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_wr_en;
  logic [1:0]  key_wr_idx;
  logic [63:0] key_wr_data;
  logic        start;
  logic        decrypt;
  logic        subkey_ready;

  logic        busy1, vld1, done1, busy3, vld3, done3;
  logic [47:0] sk1, sk3;
  logic [3:0]  rnd1, rnd3;
  logic [1:0]  pas1, pas3;

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_KEYS(1)) u1 (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .start(start), .decrypt(decrypt), .busy(busy1),
    .subkey(sk1), .subkey_valid(vld1), .subkey_ready(subkey_ready),
    .subkey_round(rnd1), .subkey_pass(pas1), .done(done1)
  );

  des_key_schedule #(.NUM_KEYS(3)) u3 (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .start(start), .decrypt(decrypt), .busy(busy3),
    .subkey(sk3), .subkey_valid(vld3), .subkey_ready(subkey_ready),
    .subkey_round(rnd3), .subkey_pass(pas3), .done(done3)
  );

  typedef struct {
    int          nk;
    logic        dec;
    int          stall_at;   // handshake index held off for 5 cycles, -1 for none
    logic [2:0]  zmask;      // slots holding an all-zero key
    bit          inject;     // mid-run key write and second start
    logic [47:0] exp_first;
    logic [47:0] exp_last;
  } run_t;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic [47:0] ktab [16];
  run_t        runs [5];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_key(input logic [1:0] idx, input logic [63:0] val);
    @(negedge clk);
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = val;
    @(negedge clk);
    key_wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {62'd0, busy1, busy3}, 64'd0);
  endtask

  task automatic run_stream(input run_t rc);
    int m, h, stall_cnt, p, r, slot;
    bit injected;
    logic dird, exp_vld, v, b, d;
    logic [47:0] exp_sk, sk, first_sk, last_sk;
    logic [3:0] rn;
    logic [1:0] ps;
    @(negedge clk);
    decrypt = rc.dec; start = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 1; h = 0; stall_cnt = 0; injected = 0;
    first_sk = '0; last_sk = '0;
    for (int it = 0; it < 17*rc.nk + 10 && m <= 17*rc.nk + 2; it++) begin
      v  = (rc.nk == 1) ? vld1  : vld3;
      b  = (rc.nk == 1) ? busy1 : busy3;
      d  = (rc.nk == 1) ? done1 : done3;
      sk = (rc.nk == 1) ? sk1   : sk3;
      rn = (rc.nk == 1) ? rnd1  : rnd3;
      ps = (rc.nk == 1) ? pas1  : pas3;
      exp_vld = (m <= 17*rc.nk) && (((m - 1) % 17) != 0);
      check($sformatf("valid m=%0d", m), {63'd0, v}, {63'd0, exp_vld});
      check($sformatf("busy m=%0d", m), {63'd0, b}, {63'd0, (m <= 17*rc.nk + 1)});
      check($sformatf("done m=%0d", m), {63'd0, d}, {63'd0, (m == 17*rc.nk + 1)});
      key_wr_en = 1'b0;
      if (rc.inject && m == 5 && !injected) begin
        injected = 1;
        key_wr_en = 1'b1; key_wr_idx = 2'd0; key_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1; decrypt = ~rc.dec;
      end else begin
        start = 1'b0;
      end
      if (exp_vld) begin
        p = h / 16; r = h % 16;
        dird = (rc.nk == 1) ? rc.dec : (rc.dec ^ (p == 1));
        slot = (rc.nk == 1) ? 0 : (rc.dec ? 2 - p : p);
        exp_sk = rc.zmask[slot] ? 48'h0 : (dird ? ktab[15-r] : ktab[r]);
        check($sformatf("subkey p%0d r%0d", p, r), {16'd0, sk}, {16'd0, exp_sk});
        check($sformatf("round p%0d r%0d", p, r), {60'd0, rn}, 64'(r));
        check($sformatf("pass p%0d r%0d", p, r), {62'd0, ps}, 64'(p));
        if (h == 0) first_sk = sk;
        last_sk = sk;
        if (h == rc.stall_at && stall_cnt < 5) begin
          subkey_ready = 1'b0;
          stall_cnt++;
        end else begin
          subkey_ready = 1'b1;
          h++; m++;
        end
      end else begin
        check($sformatf("subkey_gated m=%0d", m), {16'd0, sk}, 64'd0);
        m++;
      end
      @(negedge clk);
    end
    start = 1'b0; key_wr_en = 1'b0; subkey_ready = 1'b1;
    check("run_completed", 64'(m), 64'(17*rc.nk + 3));
    check("handshake_count", 64'(h), 64'(16*rc.nk));
    check("first_subkey", {16'd0, first_sk}, {16'd0, rc.exp_first});
    check("last_subkey", {16'd0, last_sk}, {16'd0, rc.exp_last});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    ktab[0]  = 48'b000110_110000_001011_101111_111111_000111_000001_110010;
    ktab[1]  = 48'b011110_011010_111011_011001_110110_111100_100111_100101;
    ktab[2]  = 48'b010101_011111_110010_001010_010000_101100_111110_011001;
    ktab[3]  = 48'b011100_101010_110111_010110_110110_110011_010100_011101;
    ktab[4]  = 48'b011111_001110_110000_000111_111010_110101_001110_101000;
    ktab[5]  = 48'b011000_111010_010100_111110_010100_000111_101100_101111;
    ktab[6]  = 48'b111011_001000_010010_110111_111101_100001_100010_111100;
    ktab[7]  = 48'b111101_111000_101000_111010_110000_010011_101111_111011;
    ktab[8]  = 48'b111000_001101_101111_101011_111011_011110_011110_000001;
    ktab[9]  = 48'b101100_011111_001101_000111_101110_100100_011001_001111;
    ktab[10] = 48'b001000_010101_111111_010011_110111_101101_001110_000110;
    ktab[11] = 48'b011101_010111_000111_110101_100101_000110_011111_101001;
    ktab[12] = 48'b100101_111100_010111_010001_111110_101011_101001_000001;
    ktab[13] = 48'b010111_110100_001110_110111_111100_101110_011100_111010;
    ktab[14] = 48'b101111_111001_000110_001101_001111_010011_111100_001010;
    ktab[15] = 48'b110010_110011_110110_001011_000011_100001_011111_110101;

    runs[0] = '{nk:1, dec:1'b0, stall_at:-1, zmask:3'b000, inject:0, exp_first:48'h1B02EFFC7072, exp_last:48'hCB3D8B0E17F5};
    runs[1] = '{nk:1, dec:1'b1, stall_at:-1, zmask:3'b000, inject:0, exp_first:48'hCB3D8B0E17F5, exp_last:48'h1B02EFFC7072};
    runs[2] = '{nk:3, dec:1'b0, stall_at:-1, zmask:3'b000, inject:1, exp_first:48'h1B02EFFC7072, exp_last:48'hCB3D8B0E17F5};
    runs[3] = '{nk:3, dec:1'b1, stall_at:-1, zmask:3'b000, inject:0, exp_first:48'hCB3D8B0E17F5, exp_last:48'h1B02EFFC7072};
    runs[4] = '{nk:1, dec:1'b0, stall_at:6,  zmask:3'b000, inject:0, exp_first:48'h1B02EFFC7072, exp_last:48'hCB3D8B0E17F5};

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = 2'd0; key_wr_data = '0;
    start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {62'd0, busy1, busy3}, 64'd0);
    check("rst_valid", {62'd0, vld1, vld3}, 64'd0);
    check("rst_done", {62'd0, done1, done3}, 64'd0);
    check("rst_subkey1", {16'd0, sk1}, 64'd0);
    check("rst_subkey3", {16'd0, sk3}, 64'd0);
    check("rst_round_pass", {52'd0, rnd1, rnd3, pas1, pas3}, 64'd0);
    rst = 1'b0;

    write_key(2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int s = 0; s < 3; s++) write_key(2'(s), KEY);

    for (int i = 0; i < 5; i++) begin
      run_stream(runs[i]);
      wait_idle();
    end

    // Reset in the middle of pass 0 round 8.
    @(negedge clk);
    decrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0; n = 0;
    while (!found && n < 40) begin
      if (vld3 && rnd3 == 4'd8 && pas3 == 2'd0) found = 1;
      else begin @(negedge clk); n++; end
    end
    check("reached_round8", {63'd0, found}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {62'd0, vld1, vld3}, 64'd0);
    check("midrst_busy", {62'd0, busy1, busy3}, 64'd0);
    check("midrst_done", {62'd0, done1, done3}, 64'd0);
    check("midrst_subkey", {16'd0, sk3}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_stream('{nk:1, dec:1'b0, stall_at:-1, zmask:3'b111, inject:0, exp_first:48'h0, exp_last:48'h0});
    wait_idle();

    // Slot 2 left at zero to expose pass ordering.
    write_key(2'd0, KEY);
    write_key(2'd1, KEY);
    run_stream('{nk:3, dec:1'b0, stall_at:-1, zmask:3'b100, inject:0, exp_first:48'h1B02EFFC7072, exp_last:48'h0});
    wait_idle();
    run_stream('{nk:3, dec:1'b1, stall_at:-1, zmask:3'b100, inject:0, exp_first:48'h0, exp_last:48'h1B02EFFC7072});
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
